// File: rtl/multdiv_sched_pkg.sv
// Shared types and constants for the multdiv scheduler.
// State encoding, exception codes and the writeback bundle.
package multdiv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } md_state_e;

  localparam logic [4:0]  MD_RSTATUS_REG = 5'd30;
  localparam logic [31:0] MD_MULT_EXC    = 32'd4;
  localparam logic [31:0] MD_DIV_EXC     = 32'd5;

  // 38-bit writeback bundle: valid + reg + data
  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] data;
  } md_wb_t;

endpackage

// File: rtl/multdiv_sched_wb_hold.sv
// Holding register for a multdiv result displaced by a W-stage write.
// Load/clear register, clear wins.
module md_wb_hold
  import multdiv_sched_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  md_wb_t d,
  output md_wb_t q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_sched.sv
// Sequences the shared multdiv unit, tracks the in-flight op
// and arbitrates the regfile write port against the W stage.
module multdiv_sched
  import multdiv_sched_pkg::*;
#(
  parameter int          TIMEOUT     = 64,
  parameter int          CNT_W       = 7,
  parameter logic [4:0]  RSTATUS_REG = MD_RSTATUS_REG,
  parameter logic [31:0] MULT_EXC    = MD_MULT_EXC,
  parameter logic [31:0] DIV_EXC     = MD_DIV_EXC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_mult,
  input  logic        issue_div,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  input  logic        w_we,
  input  logic [4:0]  w_reg,
  input  logic [31:0] w_data,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        busy,
  output logic        dep_stall,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       rd_q;
  logic             div_q;
  logic             latch;
  logic             to_abort;
  logic             hold_load;
  logic             hold_clr;
  logic             md_we;
  md_wb_t           formed;
  md_wb_t           md_wr;
  md_wb_t           hold_q;
  logic [4:0]       pend_reg;

  md_wb_hold u_hold (
    .clock (clock),
    .reset (reset),
    .load  (hold_load),
    .clear (hold_clr),
    .d     (formed),
    .q     (hold_q)
  );

  always_comb begin
    formed.vld  = 1'b1;
    formed.rd   = md_exception ? RSTATUS_REG : rd_q;
    formed.data = md_result;
    if (md_exception) begin
      formed.data = div_q ? DIV_EXC : MULT_EXC;
    end
  end

  always_comb begin
    state_d      = state_q;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    latch        = 1'b0;
    to_abort     = 1'b0;
    hold_load    = 1'b0;
    hold_clr     = 1'b0;
    md_we        = 1'b0;
    md_wr        = '0;
    unique case (state_q)
      IDLE: begin
        md_ctrl_mult = issue_mult;
        md_ctrl_div  = issue_div & ~issue_mult;
        if (issue_mult | issue_div) begin
          latch   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (md_ready) begin
          state_d = IDLE;
          if (formed.rd == 5'd0) begin
            state_d = IDLE;
          end else if (!w_we) begin
            md_we = 1'b1;
            md_wr = formed;
          end else begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          to_abort = 1'b1;
          state_d  = IDLE;
        end
      end
      HOLD: begin
        if (!w_we) begin
          md_we    = hold_q.vld;
          md_wr    = hold_q;
          hold_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      div_q       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      timeout_err <= to_abort;
      if (latch) begin
        cnt_q <= '0;
        rd_q  <= issue_rd;
        div_q <= ~issue_mult;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign pend_reg = (state_q == HOLD) ? hold_q.rd : rd_q;
  assign dep_stall = busy && (pend_reg != 5'd0) &&
                     ((d_rs == pend_reg) || (d_rt == pend_reg));

  // W stage always owns the port when it writes
  always_comb begin
    wb_we   = 1'b0;
    wb_reg  = '0;
    wb_data = '0;
    if (w_we) begin
      wb_we   = 1'b1;
      wb_reg  = w_reg;
      wb_data = w_data;
    end else if (md_we) begin
      wb_we   = 1'b1;
      wb_reg  = md_wr.rd;
      wb_data = md_wr.data;
    end
  end

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed self-checking bench for multdiv_sched.
// Inputs change 1ns after the rising edge; outputs checked 1ns later.
module tb_multdiv_sched;

  logic        clock;
  logic        reset;
  logic        issue_mult;
  logic        issue_div;
  logic [4:0]  issue_rd;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] md_result;
  logic        w_we;
  logic [4:0]  w_reg;
  logic [31:0] w_data;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic        busy;
  logic        dep_stall;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        timeout_err;

  int checks;
  int failures;
  int busy_cnt;
  int to_cnt;
  int md_wr_cnt;

  multdiv_sched dut (
    .clock        (clock),
    .reset        (reset),
    .issue_mult   (issue_mult),
    .issue_div    (issue_div),
    .issue_rd     (issue_rd),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .md_result    (md_result),
    .w_we         (w_we),
    .w_reg        (w_reg),
    .w_data       (w_data),
    .md_ctrl_mult (md_ctrl_mult),
    .md_ctrl_div  (md_ctrl_div),
    .busy         (busy),
    .dep_stall    (dep_stall),
    .wb_we        (wb_we),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .timeout_err  (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    issue_mult = 1'b0;
    issue_div = 1'b0;
    issue_rd = '0;
    d_rs = '0;
    d_rt = '0;
    md_ready = 1'b0;
    md_exception = 1'b0;
    md_result = '0;
    w_we = 1'b0;
    w_reg = '0;
    w_data = '0;
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wb_we", wb_we, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    chk1("rst_dep", dep_stall, 1'b0);
    reset = 1'b0;
    tick();

    // mult rd=5, ready on 33rd RUN cycle
    issue_mult = 1'b1;
    issue_rd = 5'd5;
    settle();
    chk1("t1_strobe_mult", md_ctrl_mult, 1'b1);
    chk1("t1_strobe_div", md_ctrl_div, 1'b0);
    chk1("t1_busy_issue", busy, 1'b0);
    tick();
    issue_mult = 1'b0;
    busy_cnt = 0;
    md_wr_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      settle();
      if (busy) busy_cnt++;
      if (wb_we) md_wr_cnt++;
      if (md_ctrl_mult) md_wr_cnt++;
      tick();
    end
    chk("t1_run_quiet", md_wr_cnt, 0);
    md_ready = 1'b1;
    md_result = 32'h0000_0C00;
    settle();
    if (busy) busy_cnt++;
    chk1("t1_wb_we", wb_we, 1'b1);
    chk("t1_wb_reg", 32'(wb_reg), 32'd5);
    chk("t1_wb_data", wb_data, 32'h0000_0C00);
    tick();
    md_ready = 1'b0;
    settle();
    chk("t1_busy_cycles", busy_cnt, 33);
    chk1("t1_busy_after", busy, 1'b0);
    chk1("t1_wb_we_after", wb_we, 1'b0);

    // div exception -> r30 = 5
    issue_div = 1'b1;
    issue_rd = 5'd7;
    settle();
    chk1("t2_strobe_div", md_ctrl_div, 1'b1);
    tick();
    issue_div = 1'b0;
    tick();
    tick();
    md_ready = 1'b1;
    md_exception = 1'b1;
    md_result = 32'hDEAD_BEEF;
    settle();
    chk1("t2_div_exc_we", wb_we, 1'b1);
    chk("t2_div_exc_reg", 32'(wb_reg), 32'd30);
    chk("t2_div_exc_data", wb_data, 32'd5);
    tick();
    md_ready = 1'b0;
    md_exception = 1'b0;

    // both issued: mult wins; exception -> r30 = 4
    issue_mult = 1'b1;
    issue_div = 1'b1;
    issue_rd = 5'd7;
    settle();
    chk1("t2_both_mult", md_ctrl_mult, 1'b1);
    chk1("t2_both_div", md_ctrl_div, 1'b0);
    tick();
    issue_mult = 1'b0;
    issue_div = 1'b0;
    tick();
    md_ready = 1'b1;
    md_exception = 1'b1;
    settle();
    chk("t2_mult_exc_reg", 32'(wb_reg), 32'd30);
    chk("t2_mult_exc_data", wb_data, 32'd4);
    tick();
    md_ready = 1'b0;
    md_exception = 1'b0;

    // result displaced by 3 W writes, then written from HOLD
    issue_mult = 1'b1;
    issue_rd = 5'd12;
    tick();
    issue_mult = 1'b0;
    d_rs = 5'd12;
    settle();
    chk1("t3_dep_run", dep_stall, 1'b1);
    tick();
    md_ready = 1'b1;
    md_result = 32'h0000_ABCD;
    w_we = 1'b1;
    w_reg = 5'd2;
    w_data = 32'h11;
    settle();
    chk("t3_w1_reg", 32'(wb_reg), 32'd2);
    chk("t3_w1_data", wb_data, 32'h11);
    chk1("t3_w1_dep", dep_stall, 1'b1);
    tick();
    md_ready = 1'b0;
    md_result = '0;
    issue_div = 1'b1;
    issue_rd = 5'd3;
    settle();
    chk1("t3_hold_busy", busy, 1'b1);
    chk1("t3_hold_no_strobe", md_ctrl_div, 1'b0);
    chk("t3_w2_reg", 32'(wb_reg), 32'd2);
    chk1("t3_w2_dep", dep_stall, 1'b1);
    tick();
    settle();
    chk("t3_w3_data", wb_data, 32'h11);
    chk1("t3_w3_dep", dep_stall, 1'b1);
    tick();
    issue_div = 1'b0;
    w_we = 1'b0;
    settle();
    chk1("t3_md_we", wb_we, 1'b1);
    chk("t3_md_reg", 32'(wb_reg), 32'd12);
    chk("t3_md_data", wb_data, 32'h0000_ABCD);
    chk1("t3_md_dep", dep_stall, 1'b1);
    tick();
    settle();
    chk1("t3_idle_busy", busy, 1'b0);
    chk1("t3_idle_we", wb_we, 1'b0);
    chk1("t3_idle_dep", dep_stall, 1'b0);
    d_rs = '0;

    // dependency on rt, and rd=0 discard
    issue_mult = 1'b1;
    issue_rd = 5'd9;
    tick();
    issue_mult = 1'b0;
    d_rt = 5'd9;
    settle();
    chk1("t4_dep_rt9", dep_stall, 1'b1);
    d_rt = 5'd8;
    settle();
    chk1("t4_dep_rt8", dep_stall, 1'b0);
    md_ready = 1'b1;
    md_result = 32'h99;
    settle();
    chk("t4_r9_reg", 32'(wb_reg), 32'd9);
    tick();
    md_ready = 1'b0;
    d_rt = '0;
    issue_div = 1'b1;
    issue_rd = 5'd0;
    tick();
    issue_div = 1'b0;
    settle();
    chk1("t4_rd0_busy", busy, 1'b1);
    chk1("t4_rd0_dep", dep_stall, 1'b0);
    md_ready = 1'b1;
    md_result = 32'h1234;
    settle();
    chk1("t4_rd0_no_wb", wb_we, 1'b0);
    tick();
    md_ready = 1'b0;
    settle();
    chk1("t4_rd0_idle", busy, 1'b0);

    // timeout after 64 RUN cycles without ready
    issue_mult = 1'b1;
    issue_rd = 5'd3;
    tick();
    issue_mult = 1'b0;
    to_cnt = 0;
    md_wr_cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      settle();
      if (timeout_err) to_cnt++;
      if (wb_we) md_wr_cnt++;
      if (busy) busy_cnt++;
      tick();
    end
    chk("t5_busy_cycles", busy_cnt, 64);
    chk("t5_early_pulse", to_cnt, 0);
    chk1("t5_pulse", timeout_err, 1'b1);
    chk1("t5_idle", busy, 1'b0);
    if (wb_we) md_wr_cnt++;
    tick();
    chk1("t5_pulse_end", timeout_err, 1'b0);
    chk("t5_no_wb", md_wr_cnt, 0);

    // reset mid-op abandons the result
    issue_mult = 1'b1;
    issue_rd = 5'd6;
    tick();
    issue_mult = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    reset = 1'b1;
    settle();
    chk1("t6_rst_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    md_ready = 1'b1;
    md_result = 32'h55;
    settle();
    chk1("t6_no_wb", wb_we, 1'b0);
    chk1("t6_idle", busy, 1'b0);
    tick();
    md_ready = 1'b0;
    issue_div = 1'b1;
    issue_rd = 5'd4;
    settle();
    chk1("t6_fresh_strobe", md_ctrl_div, 1'b1);
    tick();
    issue_div = 1'b0;
    settle();
    chk1("t6_fresh_busy", busy, 1'b1);
    md_ready = 1'b1;
    md_result = 32'h77;
    settle();
    chk("t6_fresh_reg", 32'(wb_reg), 32'd4);
    chk("t6_fresh_data", wb_data, 32'h77);
    tick();
    md_ready = 1'b0;
    settle();
    chk1("t6_fresh_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
